// File: rtl/memory_stage.sv
// Memory pipeline stage: issues data-memory load/store requests, extracts load data,
// flags misaligned accesses and registers the result for Writeback.
package pipelinePkg;
    typedef enum logic [1:0] {TRAP_NONE, TRAP_MIS_LOAD, TRAP_MIS_STORE, TRAP_ILLEGAL} trapType_;
    typedef enum logic [2:0] {WB_NONE, WB_ALU, WB_MEM, WB_PC4, WB_CSR} writebackType_;
    typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD} memorySize_;

    typedef struct packed {
        logic stall;
        logic flush;
    } control;

    typedef struct packed {
        logic          valid;
        logic [31:0]   programCounter;
        logic [31:0]   programCounterPlus4;
        logic [31:0]   result;
        logic [31:0]   rs2Data;
        logic [4:0]    rd;
        writebackType_ writebackType;
        logic          memoryReadEnable;
        logic          memoryWriteEnable;
        memorySize_    memorySize;
        logic          memorySigned;
        trapType_      trapType;
        logic [31:0]   faultingAddress;
        logic          csrWriteEnable;
        logic [11:0]   csrAddress;
        logic [31:0]   csrWriteData;
    } executeMemoryPayload_;

    typedef struct packed {
        logic          valid;
        logic [31:0]   programCounter;
        logic [31:0]   programCounterPlus4;
        logic [31:0]   result;
        logic [4:0]    rd;
        writebackType_ writebackType;
        trapType_      trapType;
        logic [31:0]   faultingAddress;
        logic          csrWriteEnable;
        logic [11:0]   csrAddress;
        logic [31:0]   csrWriteData;
    } memoryWritebackPayload_;
endpackage

module memory_stage
    import pipelinePkg::*;
#(
    parameter bit          ENABLE_ALIGNMENT_CHECK = 1'b1,
    parameter logic [31:0] DMEM_ADDRESS_MASK      = 32'hFFFF_FFFF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  executeMemoryPayload_   executeMemoryPayload,
    input  control                 memoryWritebackControl,
    output logic                   memoryStallRequest,
    output logic                   dmemRequestValid,
    input  logic                   dmemRequestReady,
    output logic                   dmemWriteEnable,
    output logic [31:0]            dmemAddress,
    output logic [31:0]            dmemWriteData,
    output logic [3:0]             dmemWriteStrobe,
    input  logic                   dmemResponseValid,
    input  logic [31:0]            dmemReadData,
    output memoryWritebackPayload_ memoryWritebackPayload,
    output logic                   memoryForwardEnable,
    output logic [4:0]             memoryForwardRegister,
    output logic [31:0]            memoryForwardData
);
    typedef enum logic [1:0] {IDLE, WAIT_RESP, HOLD, DRAIN} state_;

    state_                  state, nextState;
    memoryWritebackPayload_ holdBuffer;
    memoryWritebackPayload_ captured;

    logic        isLoad, isStore, memAccess, aligned, misaligned, active;
    logic        completeNow, busy, loadDone, stall, flush;
    logic [1:0]  offset;
    logic [31:0] shifted, loadData, maskedAddress;

    assign stall   = memoryWritebackControl.stall;
    assign flush   = memoryWritebackControl.flush;
    assign isLoad  = executeMemoryPayload.memoryReadEnable;
    assign isStore = executeMemoryPayload.memoryWriteEnable;
    assign memAccess = executeMemoryPayload.valid && (executeMemoryPayload.trapType == TRAP_NONE)
                       && (isLoad || isStore);

    always_comb begin
        offset  = executeMemoryPayload.result[1:0];
        aligned = 1'b1;
        case (executeMemoryPayload.memorySize)
            SIZE_WORD: begin
                offset  = 2'b00;
                aligned = !ENABLE_ALIGNMENT_CHECK || (executeMemoryPayload.result[1:0] == 2'b00);
            end
            SIZE_HALF: begin
                offset  = {executeMemoryPayload.result[1], 1'b0};
                aligned = !ENABLE_ALIGNMENT_CHECK || !executeMemoryPayload.result[0];
            end
            default: ;
        endcase
    end

    assign misaligned = memAccess && !aligned;
    assign active     = memAccess && aligned;

    assign maskedAddress   = executeMemoryPayload.result & DMEM_ADDRESS_MASK;
    assign dmemAddress     = {maskedAddress[31:2], 2'b00};
    assign dmemWriteEnable = isStore;
    assign dmemRequestValid = (state == IDLE) && active && !flush;

    always_comb begin
        dmemWriteStrobe = 4'hF;
        dmemWriteData   = executeMemoryPayload.rs2Data;
        case (executeMemoryPayload.memorySize)
            SIZE_BYTE: begin
                dmemWriteStrobe = 4'b0001 << offset;
                dmemWriteData   = {4{executeMemoryPayload.rs2Data[7:0]}};
            end
            SIZE_HALF: begin
                dmemWriteStrobe = 4'b0011 << offset;
                dmemWriteData   = {2{executeMemoryPayload.rs2Data[15:0]}};
            end
            default: ;
        endcase
    end

    assign shifted = dmemReadData >> {offset, 3'b000};

    always_comb begin
        loadData = dmemReadData;
        case (executeMemoryPayload.memorySize)
            SIZE_BYTE: loadData = {{24{executeMemoryPayload.memorySigned & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: loadData = {{16{executeMemoryPayload.memorySigned & shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        captured.valid               = executeMemoryPayload.valid;
        captured.programCounter      = executeMemoryPayload.programCounter;
        captured.programCounterPlus4 = executeMemoryPayload.programCounterPlus4;
        captured.result              = (active && isLoad && !isStore) ? loadData : executeMemoryPayload.result;
        captured.rd                  = executeMemoryPayload.rd;
        captured.writebackType       = executeMemoryPayload.writebackType;
        captured.trapType            = executeMemoryPayload.trapType;
        captured.faultingAddress     = executeMemoryPayload.faultingAddress;
        captured.csrWriteEnable      = executeMemoryPayload.csrWriteEnable;
        captured.csrAddress          = executeMemoryPayload.csrAddress;
        captured.csrWriteData        = executeMemoryPayload.csrWriteData;
        if (misaligned) begin
            captured.trapType        = isLoad ? TRAP_MIS_LOAD : TRAP_MIS_STORE;
            captured.faultingAddress = executeMemoryPayload.result;
            captured.writebackType   = WB_NONE;
        end
    end

    // Leaving HOLD counts as completion so upstream advances exactly when the buffered result retires.
    assign completeNow = ((state == IDLE) && active && isStore && dmemRequestReady && !flush)
                         || ((state == WAIT_RESP) && dmemResponseValid && !flush)
                         || (state == HOLD);
    assign busy = (state == IDLE) ? active : 1'b1;
    assign memoryStallRequest = busy && !(completeNow && !stall);

    assign loadDone = ((state == WAIT_RESP) && dmemResponseValid) || (state == HOLD);
    assign memoryForwardEnable = executeMemoryPayload.valid && (executeMemoryPayload.rd != 5'd0)
                                 && (captured.writebackType != WB_NONE) && (!isLoad || loadDone);
    assign memoryForwardRegister = executeMemoryPayload.rd;
    assign memoryForwardData     = (state == HOLD) ? holdBuffer.result : captured.result;

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (!flush && active && dmemRequestReady) begin
                if (isStore) nextState = stall ? HOLD : IDLE;
                else         nextState = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (flush)                  nextState = dmemResponseValid ? IDLE : DRAIN;
                else if (dmemResponseValid) nextState = stall ? HOLD : IDLE;
            end
            HOLD:  if (flush || !stall) nextState = IDLE;
            DRAIN: if (dmemResponseValid) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state                  <= IDLE;
            holdBuffer             <= '0;
            memoryWritebackPayload <= '0;
        end else begin
            state <= nextState;
            if (state != HOLD && nextState == HOLD)
                holdBuffer <= captured;
            // While the stage is busy a bubble is written so Writeback never sees a repeat.
            if (flush)
                memoryWritebackPayload.valid <= 1'b0;
            else if (state == HOLD) begin
                if (!stall) memoryWritebackPayload <= holdBuffer;
            end else if (!stall) begin
                if (memoryStallRequest) memoryWritebackPayload.valid <= 1'b0;
                else                    memoryWritebackPayload <= captured;
            end
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage: loads, stores, traps, flush and writeback stall.
module tb_memory_stage;
    import pipelinePkg::*;

    logic                   clock = 1'b0;
    logic                   reset;
    executeMemoryPayload_   ex;
    control                 ctl;
    logic                   stallReq, reqValid, reqReady, we, respValid, fwdEn;
    logic [31:0]            addr, wdata, rdata, fwdData;
    logic [3:0]             strobe;
    logic [4:0]             fwdReg;
    memoryWritebackPayload_ mw;
    int unsigned            checks = 0, failures = 0;

    memory_stage #(.ENABLE_ALIGNMENT_CHECK(1'b1), .DMEM_ADDRESS_MASK(32'hFFFF_FFFF)) dut (
        .clock(clock), .reset(reset), .executeMemoryPayload(ex), .memoryWritebackControl(ctl),
        .memoryStallRequest(stallReq), .dmemRequestValid(reqValid), .dmemRequestReady(reqReady),
        .dmemWriteEnable(we), .dmemAddress(addr), .dmemWriteData(wdata), .dmemWriteStrobe(strobe),
        .dmemResponseValid(respValid), .dmemReadData(rdata), .memoryWritebackPayload(mw),
        .memoryForwardEnable(fwdEn), .memoryForwardRegister(fwdReg), .memoryForwardData(fwdData)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic executeMemoryPayload_ mk(input logic [31:0] result, input logic [31:0] rs2,
                                                input logic [4:0] rd, input writebackType_ wb,
                                                input logic rdEn, input logic wrEn,
                                                input memorySize_ size, input logic sgn);
        executeMemoryPayload_ p;
        p = '0;
        p.valid = 1'b1; p.programCounter = 32'h1000; p.programCounterPlus4 = 32'h1004;
        p.result = result; p.rs2Data = rs2; p.rd = rd; p.writebackType = wb;
        p.memoryReadEnable = rdEn; p.memoryWriteEnable = wrEn; p.memorySize = size;
        p.memorySigned = sgn; p.trapType = TRAP_NONE;
        return p;
    endfunction

    task automatic test_reset();
        reset = 1'b1; ex = '0; ctl = '0; reqReady = 1'b0; respValid = 1'b0; rdata = '0;
        tick(); tick();
        reset = 1'b0; #1;
        checks++; if (mw !== '0) begin failures++; $display("FAIL reset_payload got=%h exp=0", mw); end
        checks++; if (stallReq !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stallReq); end
        checks++; if (reqValid !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", reqValid); end
    endtask

    task automatic test_load_word();
        ex = mk(32'h100, 32'h0, 5'd5, WB_MEM, 1'b1, 1'b0, SIZE_WORD, 1'b0);
        reqReady = 1'b1; #1;
        checks++; if (reqValid !== 1'b1) begin failures++; $display("FAIL lw_req got=%b exp=1", reqValid); end
        checks++; if (addr !== 32'h100) begin failures++; $display("FAIL lw_addr got=%h exp=100", addr); end
        checks++; if (stallReq !== 1'b1) begin failures++; $display("FAIL lw_stall_c0 got=%b exp=1", stallReq); end
        tick();
        reqReady = 1'b0; #1;
        checks++; if (reqValid !== 1'b0) begin failures++; $display("FAIL lw_req_c1 got=%b exp=0", reqValid); end
        checks++; if (stallReq !== 1'b1) begin failures++; $display("FAIL lw_stall_c1 got=%b exp=1", stallReq); end
        checks++; if (fwdEn !== 1'b0) begin failures++; $display("FAIL lw_fwd_c1 got=%b exp=0", fwdEn); end
        tick();
        respValid = 1'b1; rdata = 32'hDEADBEEF; #1;
        checks++; if (stallReq !== 1'b0) begin failures++; $display("FAIL lw_stall_c2 got=%b exp=0", stallReq); end
        checks++; if (fwdEn !== 1'b1 || fwdData !== 32'hDEADBEEF || fwdReg !== 5'd5)
            begin failures++; $display("FAIL lw_fwd got=%b/%h/%0d exp=1/deadbeef/5", fwdEn, fwdData, fwdReg); end
        tick();
        respValid = 1'b0; ex.valid = 1'b0;
        checks++; if (mw.valid !== 1'b1 || mw.result !== 32'hDEADBEEF || mw.rd !== 5'd5)
            begin failures++; $display("FAIL lw_out got=%b/%h/%0d exp=1/deadbeef/5", mw.valid, mw.result, mw.rd); end
    endtask

    task automatic test_load_extend();
        logic [31:0] addrs [4]  = '{32'h103, 32'h103, 32'h102, 32'h102};
        memorySize_  sizes [4]  = '{SIZE_BYTE, SIZE_BYTE, SIZE_HALF, SIZE_HALF};
        logic        sgns  [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] words [4]  = '{32'h80123456, 32'h80123456, 32'h80010000, 32'h80010000};
        logic [31:0] expect_ [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001};
        for (int i = 0; i < 4; i++) begin
            ex = mk(addrs[i], 32'h0, 5'd6, WB_MEM, 1'b1, 1'b0, sizes[i], sgns[i]);
            reqReady = 1'b1;
            tick();
            reqReady = 1'b0; respValid = 1'b1; rdata = words[i]; #1;
            checks++; if (fwdData !== expect_[i]) begin failures++; $display("FAIL ld_ext_fwd[%0d] got=%h exp=%h", i, fwdData, expect_[i]); end
            tick();
            respValid = 1'b0; ex.valid = 1'b0;
            checks++; if (mw.result !== expect_[i]) begin failures++; $display("FAIL ld_ext_out[%0d] got=%h exp=%h", i, mw.result, expect_[i]); end
        end
    endtask

    task automatic test_store();
        logic [31:0] addrs [3] = '{32'h102, 32'h101, 32'h104};
        memorySize_  sizes [3] = '{SIZE_HALF, SIZE_BYTE, SIZE_WORD};
        logic [31:0] rs2s  [3] = '{32'h1234ABCD, 32'h123456EF, 32'hA5A50F0F};
        logic [3:0]  strbs [3] = '{4'b1100, 4'b0010, 4'b1111};
        logic [31:0] datas [3] = '{32'hABCDABCD, 32'hEFEFEFEF, 32'hA5A50F0F};
        logic [31:0] words [3] = '{32'h100, 32'h100, 32'h104};
        for (int i = 0; i < 3; i++) begin
            ex = mk(addrs[i], rs2s[i], 5'd0, WB_NONE, 1'b0, 1'b1, sizes[i], 1'b0);
            reqReady = 1'b1; #1;
            checks++; if (reqValid !== 1'b1 || we !== 1'b1) begin failures++; $display("FAIL st_req[%0d] got=%b/%b exp=1/1", i, reqValid, we); end
            checks++; if (strobe !== strbs[i]) begin failures++; $display("FAIL st_strobe[%0d] got=%b exp=%b", i, strobe, strbs[i]); end
            checks++; if (wdata !== datas[i]) begin failures++; $display("FAIL st_data[%0d] got=%h exp=%h", i, wdata, datas[i]); end
            checks++; if (addr !== words[i]) begin failures++; $display("FAIL st_addr[%0d] got=%h exp=%h", i, addr, words[i]); end
            checks++; if (stallReq !== 1'b0) begin failures++; $display("FAIL st_stall[%0d] got=%b exp=0", i, stallReq); end
            tick();
            checks++; if (mw.valid !== 1'b1 || mw.result !== addrs[i]) begin failures++; $display("FAIL st_out[%0d] got=%b/%h exp=1/%h", i, mw.valid, mw.result, addrs[i]); end
        end
        ex.valid = 1'b0; reqReady = 1'b0;
    endtask

    task automatic test_store_not_ready();
        ex = mk(32'h108, 32'h77, 5'd0, WB_NONE, 1'b0, 1'b1, SIZE_WORD, 1'b0);
        reqReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (reqValid !== 1'b1 || stallReq !== 1'b1) begin failures++; $display("FAIL st_wait[%0d] got=%b/%b exp=1/1", i, reqValid, stallReq); end
            tick();
            checks++; if (mw.valid !== 1'b0) begin failures++; $display("FAIL st_wait_bubble[%0d] got=%b exp=0", i, mw.valid); end
        end
        reqReady = 1'b1; #1;
        checks++; if (stallReq !== 1'b0) begin failures++; $display("FAIL st_ready_stall got=%b exp=0", stallReq); end
        tick();
        checks++; if (mw.valid !== 1'b1 || mw.result !== 32'h108) begin failures++; $display("FAIL st_ready_out got=%b/%h exp=1/108", mw.valid, mw.result); end
        ex.valid = 1'b0; reqReady = 1'b0;
    endtask

    task automatic test_misaligned();
        ex = mk(32'h101, 32'h0, 5'd4, WB_MEM, 1'b1, 1'b0, SIZE_WORD, 1'b0);
        reqReady = 1'b1; #1;
        checks++; if (reqValid !== 1'b0 || stallReq !== 1'b0) begin failures++; $display("FAIL mis_lw_req got=%b/%b exp=0/0", reqValid, stallReq); end
        tick();
        checks++; if (mw.valid !== 1'b1 || mw.trapType !== TRAP_MIS_LOAD || mw.faultingAddress !== 32'h101 || mw.writebackType !== WB_NONE)
            begin failures++; $display("FAIL mis_lw_out got=%b/%0d/%h/%0d exp=1/1/101/0", mw.valid, mw.trapType, mw.faultingAddress, mw.writebackType); end
        ex = mk(32'h103, 32'h0, 5'd0, WB_NONE, 1'b0, 1'b1, SIZE_HALF, 1'b0); #1;
        checks++; if (reqValid !== 1'b0) begin failures++; $display("FAIL mis_sh_req got=%b exp=0", reqValid); end
        tick();
        checks++; if (mw.trapType !== TRAP_MIS_STORE || mw.faultingAddress !== 32'h103)
            begin failures++; $display("FAIL mis_sh_out got=%0d/%h exp=2/103", mw.trapType, mw.faultingAddress); end
        ex.valid = 1'b0; reqReady = 1'b0;
    endtask

    task automatic test_non_memory();
        ex = mk(32'h55, 32'h0, 5'd7, WB_ALU, 1'b0, 1'b0, SIZE_WORD, 1'b0); #1;
        checks++; if (stallReq !== 1'b0 || reqValid !== 1'b0) begin failures++; $display("FAIL alu_stall got=%b/%b exp=0/0", stallReq, reqValid); end
        checks++; if (fwdEn !== 1'b1 || fwdData !== 32'h55 || fwdReg !== 5'd7) begin failures++; $display("FAIL alu_fwd got=%b/%h/%0d exp=1/55/7", fwdEn, fwdData, fwdReg); end
        tick();
        checks++; if (mw.valid !== 1'b1 || mw.result !== 32'h55 || mw.writebackType !== WB_ALU) begin failures++; $display("FAIL alu_out got=%b/%h exp=1/55", mw.valid, mw.result); end
        ex.rd = 5'd0; #1;
        checks++; if (fwdEn !== 1'b0) begin failures++; $display("FAIL alu_x0_fwd got=%b exp=0", fwdEn); end
        ex.valid = 1'b0;
    endtask

    task automatic test_flush_wait();
        ex = mk(32'h200, 32'h0, 5'd8, WB_MEM, 1'b1, 1'b0, SIZE_WORD, 1'b0);
        reqReady = 1'b1;
        tick();
        reqReady = 1'b0; ctl.flush = 1'b1;
        tick();
        ctl.flush = 1'b0; ex.valid = 1'b0; #1;
        checks++; if (stallReq !== 1'b1 || mw.valid !== 1'b0) begin failures++; $display("FAIL flush_drain got=%b/%b exp=1/0", stallReq, mw.valid); end
        tick();
        respValid = 1'b1; rdata = 32'h11111111; #1;
        checks++; if (stallReq !== 1'b1) begin failures++; $display("FAIL flush_resp_stall got=%b exp=1", stallReq); end
        tick();
        respValid = 1'b0; #1;
        checks++; if (mw.valid !== 1'b0 || stallReq !== 1'b0) begin failures++; $display("FAIL flush_discard got=%b/%b exp=0/0", mw.valid, stallReq); end
        ex = mk(32'h204, 32'h0, 5'd9, WB_MEM, 1'b1, 1'b0, SIZE_WORD, 1'b0);
        reqReady = 1'b1; #1;
        checks++; if (reqValid !== 1'b1) begin failures++; $display("FAIL flush_next_req got=%b exp=1", reqValid); end
        tick();
        reqReady = 1'b0; respValid = 1'b1; rdata = 32'h22222222;
        tick();
        respValid = 1'b0; ex.valid = 1'b0;
        checks++; if (mw.valid !== 1'b1 || mw.result !== 32'h22222222) begin failures++; $display("FAIL flush_next_out got=%b/%h exp=1/22222222", mw.valid, mw.result); end
    endtask

    task automatic test_hold();
        ex = mk(32'h300, 32'h0, 5'd10, WB_MEM, 1'b1, 1'b0, SIZE_WORD, 1'b0);
        reqReady = 1'b1;
        tick();
        reqReady = 1'b0; respValid = 1'b1; rdata = 32'hCAFEF00D; ctl.stall = 1'b1; #1;
        checks++; if (stallReq !== 1'b1) begin failures++; $display("FAIL hold_enter_stall got=%b exp=1", stallReq); end
        tick();
        respValid = 1'b0; rdata = 32'h0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (stallReq !== 1'b1 || mw.valid !== 1'b0) begin failures++; $display("FAIL hold_wait[%0d] got=%b/%b exp=1/0", i, stallReq, mw.valid); end
            tick();
        end
        ctl.stall = 1'b0; #1;
        checks++; if (stallReq !== 1'b0 || fwdData !== 32'hCAFEF00D) begin failures++; $display("FAIL hold_release got=%b/%h exp=0/cafef00d", stallReq, fwdData); end
        tick();
        ex.valid = 1'b0;
        checks++; if (mw.valid !== 1'b1 || mw.result !== 32'hCAFEF00D || mw.rd !== 5'd10) begin failures++; $display("FAIL hold_out got=%b/%h/%0d exp=1/cafef00d/10", mw.valid, mw.result, mw.rd); end
    endtask

    task automatic test_reset_mid_access();
        ex = mk(32'h400, 32'h0, 5'd11, WB_MEM, 1'b1, 1'b0, SIZE_WORD, 1'b0);
        reqReady = 1'b1;
        tick();
        reqReady = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0; ex.valid = 1'b0; #1;
        checks++; if (stallReq !== 1'b0 || reqValid !== 1'b0 || mw.valid !== 1'b0)
            begin failures++; $display("FAIL reset_mid got=%b/%b/%b exp=0/0/0", stallReq, reqValid, mw.valid); end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_extend();
        test_store();
        test_store_not_ready();
        test_misaligned();
        test_non_memory();
        test_flush_wait();
        test_hold();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
